// File: rtl/cdc_hs_rx.sv
// cdc_hs_rx: receiving side of a four-phase req/ack handshake between clock domains.
// Only the req level is synchronized; the data bus is captured once that level is seen.
//
// Ports:
//   clk        local (destination) clock
//   rst        synchronous active-high reset
//   req_in     four-phase request from the source domain (asynchronous)
//   data_in    source word, held stable by the source while req is high
//   ack_out    four-phase acknowledge to the source domain (driven by a flop)
//   out_data   captured word
//   out_valid  out_data valid
//   out_ready  downstream accepts the word
//   busy       receiver is in any state other than IDLE
//   proto_err  sticky flag: req was withdrawn before ack
//   xfer_cnt   completed handshakes, wraps
module cdc_hs_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              proto_err,
    output logic [CNT_W-1:0]  xfer_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic                   req_q;

    state_t            state;
    state_t            state_n;
    logic              ack_q;
    logic              ack_n;
    logic              valid_q;
    logic              valid_n;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_n;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_n;
    logic              err_q;
    logic              err_n;

    // Plain flop chain: the only path by which req_in enters this domain.
    assign req_s = req_sync[SYNC_STAGES-1];

    // req_q retimes the synchronized level into the FSM, so that both the
    // rise (word presented) and the fall (ack released) appear
    // SYNC_STAGES+1 edges after the first edge that samples the new level.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync <= '0;
            req_q    <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
            req_q    <= req_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ack_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_n;
            ack_q   <= ack_n;
            valid_q <= valid_n;
            data_q  <= data_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        ack_n   = ack_q;
        valid_n = valid_q;
        data_n  = data_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        case (state)
            S_IDLE: begin
                ack_n   = 1'b0;
                valid_n = 1'b0;
                // data_in is quasi-static while req is high, so it is
                // safe to capture once the synchronized req is seen.
                if (req_q) begin
                    data_n  = data_in;
                    valid_n = 1'b1;
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                valid_n = 1'b1;
                // Source dropped req before we acked: flag it but still
                // deliver the word we already hold.
                if (!req_q) begin
                    err_n = 1'b1;
                end
                if (out_ready) begin
                    valid_n = 1'b0;
                    ack_n   = 1'b1;
                    cnt_n   = cnt_q + CNT_W'(1);
                    state_n = S_ACK;
                end
            end
            S_ACK: begin
                valid_n = 1'b0;
                if (!req_q) begin
                    ack_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                ack_n   = 1'b0;
                valid_n = 1'b0;
            end
        endcase
    end

    assign ack_out   = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign xfer_cnt  = cnt_q;
    assign proto_err = err_q;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_cdc_hs_rx.sv
// tb_cdc_hs_rx: self-checking bench for cdc_hs_rx.
// Table vectors, hand sequences and random transfers against a transaction model.
module tb_cdc_hs_rx;

    localparam int DW = 8;
    localparam int SS = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_in;
    logic [DW-1:0] data_in;
    logic          ack_out;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          proto_err;
    logic [CW-1:0] xfer_cnt;

    cdc_hs_rx #(
        .DATA_W     (DW),
        .SYNC_STAGES(SS),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .proto_err(proto_err),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level reference: words in acceptance order, count, sticky error.
    int            exp_cnt;
    bit            exp_err;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    typedef struct {
        logic [DW-1:0] d;
        int            rwait;
        bit            early;
        bit            exp_err;
        int            exp_cnt;
    } vec_t;

    vec_t vecs[8];

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(out_data);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    task automatic check_beats();
        chk("beat_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk("beat_word", got_q[i], exp_q[i]);
        end
    endtask

    // One full four-phase transfer. rwait = cycles of backpressure after
    // out_valid rises; early = withdraw req while the word is held.
    task automatic xfer(input logic [DW-1:0] d, input int rwait, input bit early);
        int t;
        bit seen;
        data_in   = d;
        out_ready = (rwait == 0);
        req_in    = 1'b1;
        seen      = 1'b0;
        for (t = 1; t <= 30; t++) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        // edge 0 samples req, valid appears after edge SS+1 -> SS+2 ticks
        chk("valid_latency", seen ? t : 0, SS + 2);
        if (!seen) begin
            req_in = 1'b0;
            return;
        end
        chk("cap_data", out_data, d);
        chk("ack_before_accept", ack_out, 0);
        chk("busy_hold", busy, 1);
        if (early) begin
            req_in = 1'b0;
        end
        for (int i = 0; i < rwait; i++) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, d);
            chk("hold_ack", ack_out, 0);
        end
        if (early) begin
            chk("err_set", proto_err, 1);
        end
        out_ready = 1'b1;
        tick();
        exp_q.push_back(d);
        exp_cnt++;
        exp_err = exp_err | early;
        chk("accept_ack", ack_out, 1);
        chk("accept_valid", out_valid, 0);
        chk("count", xfer_cnt, exp_cnt % (1 << CW));
        out_ready = 1'b0;
        if (early) begin
            tick();
            chk("ack_fast_release", ack_out, 0);
        end else begin
            req_in = 1'b0;
            seen   = 1'b0;
            for (t = 1; t <= 30; t++) begin
                tick();
                if (!ack_out) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("ack_fall_latency", seen ? t : 0, SS + 2);
        end
        chk("err_model", proto_err, exp_err);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 0, 1'b0, 1'b0, 1};
        vecs[1] = '{8'h3C, 10, 1'b0, 1'b0, 2};
        vecs[2] = '{8'h11, 0, 1'b0, 1'b0, 3};
        vecs[3] = '{8'h22, 0, 1'b0, 1'b0, 4};
        vecs[4] = '{8'h33, 0, 1'b0, 1'b0, 5};
        vecs[5] = '{8'h44, 0, 1'b0, 1'b0, 6};
        vecs[6] = '{8'h5A, 6, 1'b1, 1'b1, 7};
        vecs[7] = '{8'hC3, 2, 1'b0, 1'b1, 0};

        rst       = 1'b1;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        clear_model();
        chk("rst_ack", ack_out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_cnt", xfer_cnt, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_quiet",
                {ack_out, out_valid, busy, proto_err, xfer_cnt, out_data}, 0);
        end

        for (int i = 0; i < 8; i++) begin
            xfer(vecs[i].d, vecs[i].rwait, vecs[i].early);
            chk("tbl_err", proto_err, vecs[i].exp_err);
            chk("tbl_cnt", xfer_cnt, vecs[i].exp_cnt);
        end
        check_beats();

        // Sticky error survives idle time, clears only on reset.
        repeat (5) tick();
        chk("err_sticky", proto_err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        chk("err_cleared", proto_err, 0);
        chk("cnt_cleared", xfer_cnt, 0);

        // Reset while in ACK with req still high.
        data_in   = 8'h77;
        out_ready = 1'b1;
        req_in    = 1'b1;
        for (int i = 0; i < 30 && !ack_out; i++) begin
            tick();
        end
        chk("ack_before_rst", ack_out, 1);
        rst = 1'b1;
        tick();
        chk("midrst_ack", ack_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_cnt", xfer_cnt, 0);
        rst = 1'b0;
        clear_model();
        // req still high: treated as a fresh request after reset.
        xfer(8'h77, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            xfer(DW'($urandom), $urandom_range(0, 3), 1'b0);
        end
        chk("wrap_cnt", xfer_cnt, 1);
        check_beats();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        for (int i = 0; i < 24; i++) begin
            bit e;
            e = ($urandom_range(0, 5) == 0);
            xfer(DW'($urandom),
                 e ? 4 + $urandom_range(0, 3) : $urandom_range(0, 5), e);
        end
        check_beats();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
